fir_tap_loader: RTL and testbench

- Sequencer that reloads the FIR filter's tap coefficients from a banked coefficient ROM on request.
- Drives the filter's tap-write port, index 0 first, one tap per clock.
- Gates the filter's sample clock-enable while taps are being rewritten, and counts any samples it drops.
- Sits between the top-level control and the filter/coefficient memory; it replaces the ad-hoc start-button loader.

---
 rtl/fir_tap_loader.sv | 142 ++++++++++++++
 tb/tb_fir_tap_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_loader.sv
// fir_tap_loader: reloads the FIR filter's tap coefficients from a banked,
// registered coefficient ROM. One request loads NTAPS taps (index 0 first,
// one per clock). While busy the filter's sample enable is gated off and
// the dropped samples are counted. One further request can be queued while
// a load is in progress; the most recent request wins.
// NBANKS must be at least 2 and NTAPS at least 2.
module fir_tap_loader #(
   parameter int NTAPS  = 16,
   parameter int TW     = 16,
   parameter int NBANKS = 4,
   parameter int BW     = $clog2(NBANKS),
   parameter int AW     = $clog2(NBANKS*NTAPS)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_load_req,
   input  logic [BW-1:0] i_bank,
   output logic [AW-1:0] o_rom_addr,
   input  logic [TW-1:0] i_rom_data,
   output logic          o_tap_wr,
   output logic [TW-1:0] o_tap,
   input  logic          i_ce_in,
   output logic          o_fir_ce,
   output logic          o_busy,
   output logic          o_done,
   output logic [BW-1:0] o_active_bank,
   output logic [7:0]    o_drop_count
);

   localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NTAPS-1);

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_LOAD, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   base;          // first ROM address of the bank being loaded
   logic [AW-1:0]   last_addr;     // last ROM address of that bank
   logic [BW-1:0]   cur_bank;      // bank being loaded (already clamped)
   logic [IW-1:0]   idx;           // tap index being written in LOAD
   logic            pending;
   logic [BW-1:0]   pending_bank;  // raw bank; clamped when it is latched
   logic            start_load;
   logic [BW-1:0]   start_bank;

   // Out-of-range bank selects fall back to the highest bank.
   function automatic logic [BW-1:0] clamp_bank(input logic [BW-1:0] b);
      if (int'(b) >= NBANKS) return BW'(NBANKS-1);
      return b;
   endfunction

   function automatic logic [AW-1:0] bank_base(input logic [BW-1:0] b);
      return AW'(int'(b) * NTAPS);
   endfunction

   // A load starts from IDLE on a request, or straight out of DONE when a
   // request is queued or arrives in that very cycle (the newest one wins).
   always_comb begin
      start_load = ((state == S_IDLE) && i_load_req) ||
                   ((state == S_DONE) && (pending || i_load_req));
      start_bank = clamp_bank(i_load_req ? i_bank : pending_bank);
      last_addr  = base + AW'(NTAPS-1);
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic: PRIME covers the registered ROM's read latency.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_load_req) state_nxt = S_PRIME;
         S_PRIME: state_nxt = S_LOAD;
         S_LOAD:  if (idx == IDX_LAST) state_nxt = S_DONE;
         S_DONE:  state_nxt = start_load ? S_PRIME : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic: tap data comes straight from the ROM during LOAD.
   always_comb begin
      o_busy   = (state != S_IDLE);
      o_done   = (state == S_DONE);
      o_tap_wr = (state == S_LOAD);
      o_tap    = o_tap_wr ? i_rom_data : '0;
      o_fir_ce = i_ce_in & ~o_busy;
   end

   // ROM address / tap index sequencing. The address runs one ahead of the
   // tap being written and parks on the bank's last entry.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_rom_addr <= '0;
         base       <= '0;
         cur_bank   <= '0;
         idx        <= '0;
      end else begin
         if (start_load) begin
            cur_bank   <= start_bank;
            base       <= bank_base(start_bank);
            o_rom_addr <= bank_base(start_bank);
            idx        <= '0;
         end else if (state == S_PRIME) begin
            o_rom_addr <= base + AW'(1);
         end else if (state == S_LOAD) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            if (o_rom_addr != last_addr) o_rom_addr <= o_rom_addr + AW'(1);
         end
      end
   end

   // One-deep request queue: requests during a load overwrite each other;
   // DONE always consumes whatever is queued.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pending      <= 1'b0;
         pending_bank <= '0;
      end else if (state == S_DONE) begin
         pending <= 1'b0;
      end else if (o_busy && i_load_req) begin
         pending      <= 1'b1;
         pending_bank <= i_bank;
      end
   end

   // The resident bank changes only once a load has fully completed.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)              o_active_bank <= '0;
      else if (state == S_DONE) o_active_bank <= cur_bank;
   end

   // Saturating count of samples swallowed while busy.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         o_drop_count <= '0;
      else if (i_ce_in && o_busy && (o_drop_count != 8'hFF))
         o_drop_count <= o_drop_count + 8'd1;
   end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Bench for fir_tap_loader: registered ROM model, tap scoreboard and
// cycle-accurate checks of address, strobes, gating and the drop counter.
module tb_fir_tap_loader;

   logic        clk, rst;
   logic        req, ce;
   logic [1:0]  bank;
   logic [5:0]  addr;
   logic [15:0] rom_q, tap;
   logic        tap_wr, fir_ce, busy, done;
   logic [1:0]  act;
   logic [7:0]  drops;

   logic        req3, ce3;
   logic [1:0]  bank3;
   logic [5:0]  addr3;
   logic [15:0] rom3_q, tap3;
   logic        tap_wr3, fir_ce3, busy3, done3;
   logic [1:0]  act3;
   logic [7:0]  drops3;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int tap_cnt  = 0;
   bit sb_en = 1'b1;
   logic [15:0] exp_q[$];

   fir_tap_loader u_dut (
      .i_clk(clk), .i_reset(rst), .i_load_req(req), .i_bank(bank),
      .o_rom_addr(addr), .i_rom_data(rom_q), .o_tap_wr(tap_wr), .o_tap(tap),
      .i_ce_in(ce), .o_fir_ce(fir_ce), .o_busy(busy), .o_done(done),
      .o_active_bank(act), .o_drop_count(drops)
   );

   fir_tap_loader #(.NBANKS(3)) u_dut3 (
      .i_clk(clk), .i_reset(rst), .i_load_req(req3), .i_bank(bank3),
      .o_rom_addr(addr3), .i_rom_data(rom3_q), .o_tap_wr(tap_wr3), .o_tap(tap3),
      .i_ce_in(ce3), .o_fir_ce(fir_ce3), .o_busy(busy3), .o_done(done3),
      .o_active_bank(act3), .o_drop_count(drops3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Distinct value per address (odd multiplier is injective mod 2^16).
   function automatic logic [15:0] rom_val(input int a);
      return 16'(a * 32'h1F3 + 32'h5A5A);
   endfunction

   always @(posedge clk) begin
      rom_q  <= rom_val(int'(addr));
      rom3_q <= rom_val(int'(addr3));
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic push_bank(input int b);
      for (int k = 0; k < 16; k++) exp_q.push_back(rom_val(b*16 + k));
   endtask

   // Scoreboard monitor: every written tap must match the next expected one.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (tap_wr) begin
         tap_cnt++;
         if (sb_en) begin
            if (exp_q.size() == 0) chk("tap_extra", 32'd1, 32'd0);
            else                   chk("tap", tap, exp_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1; req = 1'b0; req3 = 1'b0; ce = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_addr", addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr", tap_wr, 0);
      chk("rst_done", done, 0);
      chk("rst_act", act, 0);
      chk("rst_drops", drops, 0);
      chk("rst_busy3", busy3, 0);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Returns in cycle 1 (PRIME) of the requested load.
   task automatic pulse(input logic [1:0] b);
      bank = b; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, d1, t0, ea, low;
      rst = 1'b1; req = 1'b0; ce = 1'b0; bank = '0;
      req3 = 1'b0; ce3 = 1'b0; bank3 = '0;

      // Basic bank-2 load with exact cycle timing
      do_reset();
      d0 = done_cnt;
      push_bank(2);
      pulse(2);
      for (int c = 1; c <= 19; c++) begin
         ea = (c == 1) ? 32 : ((31 + c > 47) ? 47 : 31 + c);
         chk("t1_addr", addr, ea);
         chk("t1_wr", tap_wr, (c >= 2 && c <= 17));
         chk("t1_done", done, (c == 18));
         chk("t1_busy", busy, (c <= 18));
         if (c == 18) chk("t1_act_old", act, 0);
         if (c == 19) chk("t1_act", act, 2);
         @(negedge clk);
      end
      chk("t1_ndone", done_cnt - d0, 1);
      chk("t1_qempty", exp_q.size(), 0);

      // Queued requests: last one wins, serviced straight out of DONE
      do_reset();
      d0 = done_cnt;
      push_bank(1);
      pulse(1);
      repeat (4) @(negedge clk);
      bank = 2'd3; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (3) @(negedge clk);
      bank = 2'd0; req = 1'b1;
      push_bank(0);
      @(negedge clk);
      req = 1'b0;
      repeat (8) @(negedge clk);
      chk("t2_done18", done, 1);
      chk("t2_addr18", addr, 31);
      @(negedge clk);
      chk("t2_busy19", busy, 1);
      chk("t2_addr19", addr, 0);
      chk("t2_done19", done, 0);
      wait_idle(40);
      chk("t2_ndone", done_cnt - d0, 2);
      chk("t2_act", act, 0);
      chk("t2_qempty", exp_q.size(), 0);

      // Sample gating and drop count over one load
      do_reset();
      ce = 1'b1;
      push_bank(0);
      low = 0;
      bank = 2'd0; req = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (i == 0) req = 1'b0;
         if (!fir_ce) low++;
      end
      chk("t3_lowcyc", low, 18);
      chk("t3_drops", drops, 18);
      ce = 1'b0; #1;
      chk("t3_ce0", fir_ce, 0);
      ce = 1'b1; #1;
      chk("t3_ce1", fir_ce, 1);
      ce = 1'b0;
      chk("t3_qempty", exp_q.size(), 0);

      // Held request: 15 back-to-back loads, counter saturates
      do_reset();
      ce = 1'b1; sb_en = 1'b0;
      d0 = done_cnt;
      bank = 2'd1; req = 1'b1;
      repeat (253) @(negedge clk);
      req = 1'b0;
      chk("t4_busy", busy, 1);
      chk("t4_drops_pre", drops, 252);
      wait_idle(40);
      chk("t4_drops_sat", drops, 255);
      chk("t4_ndone", done_cnt - d0, 15);
      ce = 1'b0;
      exp_q.delete();
      sb_en = 1'b1;

      // Reset in the middle of a load
      do_reset();
      push_bank(1);
      pulse(1);
      wait_idle(30);
      chk("t5_act1", act, 1);
      push_bank(2);
      pulse(2);
      repeat (7) @(negedge clk);
      sb_en = 1'b0;
      rst = 1'b1; #1;
      chk("t5_wr", tap_wr, 0);
      chk("t5_busy", busy, 0);
      chk("t5_act", act, 0);
      chk("t5_done", done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      sb_en = 1'b1;
      d1 = done_cnt;
      repeat (25) @(negedge clk);
      chk("t5_nodone", done_cnt - d1, 0);
      t0 = tap_cnt;
      push_bank(3);
      pulse(3);
      wait_idle(30);
      chk("t5_taps", tap_cnt - t0, 16);
      chk("t5_ndone", done_cnt - d1, 1);
      chk("t5_act3", act, 3);
      chk("t5_qempty", exp_q.size(), 0);

      // Bank clamp with NBANKS=3: bank 3 loads bank 2
      bank3 = 2'd3; req3 = 1'b1;
      @(negedge clk);
      req3 = 1'b0;
      for (int c = 1; c <= 19; c++) begin
         ea = (c == 1) ? 32 : ((31 + c > 47) ? 47 : 31 + c);
         chk("t6_addr", addr3, ea);
         chk("t6_wr", tap_wr3, (c >= 2 && c <= 17));
         if (c >= 2 && c <= 17) chk("t6_tap", tap3, rom_val(32 + c - 2));
         else                   chk("t6_tap0", tap3, 0);
         chk("t6_done", done3, (c == 18));
         if (c == 19) chk("t6_act", act3, 2);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
